// File: rtl/obi_cache_cmd_queue.sv
// obi_cache_cmd_queue
//   OBI slave front end for the key/value cache controller. The master stages
//   value and key words, then writes a non-zero opcode. That write enqueues
//   {op, key, value} into a command FIFO. The controller takes commands from the
//   head of that FIFO. Its results are pushed into a response FIFO, which the
//   master inspects and pops through the POP word.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   obi_req_i / obi_gnt_o        OBI A-channel handshake
//   obi_addr_i, obi_we_i,        byte address, write enable, write data
//   obi_wdata_i
//   obi_rvalid_o, obi_rready_i   OBI R-channel handshake
//   obi_rdata_o, obi_err_o       response data / error (qualified by rvalid)
//   cmd_valid_o / cmd_ready_i    head command handshake towards the controller
//   cmd_op_o, cmd_key_o,         head command fields
//   cmd_value_o
//   rsp_valid_i, rsp_succ_i,     one-cycle controller result
//   rsp_value_i
//
// Word map (NV value words, NK key words, C = NV+NK):
//   0..NV-1 value staging (RW), NV..C-1 key staging (RW), C op (WO),
//   C+1 status (RO), C+2..C+1+NV response head value (RO), C+2+NV POP (RO).
module obi_cache_cmd_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 64,
  parameter int OP_WIDTH    = 2,
  parameter int CMD_DEPTH   = 4,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   obi_req_i,
  output logic                   obi_gnt_o,
  input  logic [DATA_WIDTH-1:0]  obi_addr_i,
  input  logic                   obi_we_i,
  input  logic [DATA_WIDTH-1:0]  obi_wdata_i,
  output logic                   obi_rvalid_o,
  input  logic                   obi_rready_i,
  output logic [DATA_WIDTH-1:0]  obi_rdata_o,
  output logic                   obi_err_o,
  output logic                   cmd_valid_o,
  input  logic                   cmd_ready_i,
  output logic [OP_WIDTH-1:0]    cmd_op_o,
  output logic [KEY_WIDTH-1:0]   cmd_key_o,
  output logic [VALUE_WIDTH-1:0] cmd_value_o,
  input  logic                   rsp_valid_i,
  input  logic                   rsp_succ_i,
  input  logic [VALUE_WIDTH-1:0] rsp_value_i
);

  localparam int BYTE_SH = $clog2(DATA_WIDTH/8);
  localparam int NV      = VALUE_WIDTH/DATA_WIDTH;
  localparam int NK      = KEY_WIDTH/DATA_WIDTH;
  localparam int C       = NV + NK;
  localparam int W_OP    = C;
  localparam int W_STAT  = C + 1;
  localparam int W_RVAL  = C + 2;
  localparam int W_POP   = C + 2 + NV;
  localparam int SW      = $clog2(C);
  localparam int VIW     = (NV > 1) ? $clog2(NV) : 1;
  localparam int CPW     = $clog2(CMD_DEPTH);
  localparam int RPW     = $clog2(RSP_DEPTH);
  localparam int CCW     = CPW + 1;
  localparam int RCW     = RPW + 1;

  typedef struct packed {
    logic [OP_WIDTH-1:0]    op;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } cmd_t;

  typedef struct packed {
    logic                   succ;
    logic [VALUE_WIDTH-1:0] value;
  } rsp_t;

  // staging words: [NV-1:0] value (word 0 = LSW), [C-1:NV] key
  logic [C-1:0][DATA_WIDTH-1:0] stage_q;

  cmd_t [CMD_DEPTH-1:0] cmd_mem;
  logic [CPW-1:0]       cmd_wr, cmd_rd;
  logic [CCW-1:0]       cmd_cnt;

  rsp_t [RSP_DEPTH-1:0] rsp_mem;
  logic [RPW-1:0]       rsp_wr, rsp_rd;
  logic [RCW-1:0]       rsp_cnt;
  logic [RCW-1:0]       inflight;

  logic                  rvalid_q, err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // ---------------- decode ----------------
  logic [DATA_WIDTH-1:0] widx, rv_off;
  logic is_stage, is_op, is_stat, is_rval, is_pop, op_nz;

  assign widx     = obi_addr_i >> BYTE_SH;
  assign rv_off   = widx - DATA_WIDTH'(W_RVAL);
  assign is_stage = widx < DATA_WIDTH'(C);
  assign is_op    = widx == DATA_WIDTH'(W_OP);
  assign is_stat  = widx == DATA_WIDTH'(W_STAT);
  assign is_rval  = (widx >= DATA_WIDTH'(W_RVAL)) && (widx < DATA_WIDTH'(W_POP));
  assign is_pop   = widx == DATA_WIDTH'(W_POP);
  assign op_nz    = obi_wdata_i[OP_WIDTH-1:0] != '0;

  // ---------------- FIFO heads / issue ----------------
  cmd_t                         cmd_head;
  rsp_t                         rsp_head;
  logic [NV-1:0][DATA_WIDTH-1:0] rsp_head_words;
  logic                         cmd_empty, cmd_full, rsp_empty;
  logic [RCW:0]                 credit_used;
  logic                         cmd_issue, rsp_acc;

  assign cmd_head       = cmd_mem[cmd_rd];
  assign rsp_head       = rsp_mem[rsp_rd];
  assign rsp_head_words = rsp_head.value;
  assign cmd_empty      = cmd_cnt == '0;
  assign cmd_full       = cmd_cnt == CCW'(CMD_DEPTH);
  assign rsp_empty      = rsp_cnt == '0;

  // A command is only offered while a response slot is guaranteed for it,
  // which is what keeps the response FIFO from ever overflowing.
  assign credit_used = (RCW+1)'(rsp_cnt) + (RCW+1)'(inflight);
  assign cmd_valid_o = ~cmd_empty & (credit_used < (RCW+1)'(RSP_DEPTH));
  assign cmd_op_o    = cmd_head.op;
  assign cmd_key_o   = cmd_head.key;
  assign cmd_value_o = cmd_head.value;

  assign cmd_issue = cmd_valid_o & cmd_ready_i;
  // results with nothing outstanding are a controller protocol error: dropped
  assign rsp_acc   = rsp_valid_i & (inflight != '0);

  // ---------------- A-channel ----------------
  logic enq_req, cmd_block, r_stall;

  assign enq_req   = obi_we_i & is_op & op_nz;
  // a same-cycle controller pop frees a slot, so a full FIFO does not block then
  assign cmd_block = enq_req & cmd_full & ~cmd_issue;
  assign r_stall   = rvalid_q & ~obi_rready_i;
  assign obi_gnt_o = obi_req_i & ~r_stall & ~cmd_block;

  // access result, applied only when granted
  logic [DATA_WIDTH-1:0] acc_rdata;
  logic                  acc_err, do_stage_wr, do_enq, do_pop;

  always_comb begin
    acc_rdata   = '0;
    acc_err     = 1'b0;
    do_stage_wr = 1'b0;
    do_enq      = 1'b0;
    do_pop      = 1'b0;
    if (obi_we_i) begin
      if (is_stage)   do_stage_wr = 1'b1;
      else if (is_op) do_enq      = op_nz;   // op 0 is an OKAY no-op
      else            acc_err     = 1'b1;    // RO words and unmapped
    end else begin
      if (is_stage) begin
        acc_rdata = stage_q[widx[SW-1:0]];
      end else if (is_stat) begin
        acc_rdata = DATA_WIDTH'({rsp_cnt, cmd_cnt, inflight});
      end else if (is_rval) begin
        if (!rsp_empty) acc_rdata = rsp_head_words[rv_off[VIW-1:0]];
      end else if (is_pop) begin
        if (rsp_empty) begin
          acc_err = 1'b1;
        end else begin
          acc_rdata = DATA_WIDTH'({1'b1, rsp_head.succ});
          do_pop    = 1'b1;
        end
      end else begin
        acc_err = 1'b1;                      // op word read or unmapped
      end
    end
  end

  logic cmd_push, rsp_pop;
  assign cmd_push = obi_gnt_o & do_enq;
  assign rsp_pop  = obi_gnt_o & do_pop;

  // ---------------- R-channel ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (obi_gnt_o) begin
      rvalid_q <= 1'b1;
      rdata_q  <= acc_rdata;
      err_q    <= acc_err;
    end else if (obi_rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_err_o    = err_q;

  // ---------------- staging ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stage_q <= '0;
    else if (obi_gnt_o && do_stage_wr)
      stage_q[widx[SW-1:0]] <= obi_wdata_i;
  end

  // ---------------- command FIFO ----------------
  cmd_t new_cmd;
  assign new_cmd = '{op:    obi_wdata_i[OP_WIDTH-1:0],
                     key:   stage_q[C-1:NV],
                     value: stage_q[NV-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_mem <= '0;
      cmd_wr  <= '0;
      cmd_rd  <= '0;
      cmd_cnt <= '0;
    end else begin
      if (cmd_push) begin
        cmd_mem[cmd_wr] <= new_cmd;
        cmd_wr          <= cmd_wr + 1'b1;
      end
      if (cmd_issue) cmd_rd <= cmd_rd + 1'b1;
      cmd_cnt <= cmd_cnt + CCW'(cmd_push) - CCW'(cmd_issue);
    end
  end

  // ---------------- in-flight counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      inflight <= '0;
    else if (cmd_issue && !rsp_acc)
      inflight <= inflight + 1'b1;
    else if (!cmd_issue && rsp_acc)
      inflight <= inflight - 1'b1;
  end

  // ---------------- response FIFO ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_mem <= '0;
      rsp_wr  <= '0;
      rsp_rd  <= '0;
      rsp_cnt <= '0;
    end else begin
      if (rsp_acc) begin
        rsp_mem[rsp_wr] <= '{succ: rsp_succ_i, value: rsp_value_i};
        rsp_wr          <= rsp_wr + 1'b1;
      end
      if (rsp_pop) rsp_rd <= rsp_rd + 1'b1;
      rsp_cnt <= rsp_cnt + RCW'(rsp_acc) - RCW'(rsp_pop);
    end
  end

endmodule

// File: tb/tb_obi_cache_cmd_queue.sv
// Directed bench for obi_cache_cmd_queue (default parameters: NV=2, NK=1, C=3).
// Word map: 0,1 value, 2 key, 3 op, 4 status, 5,6 rsp value, 7 POP.
// Status = {rsp_count[8:6], cmd_count[5:3], inflight[2:0]}.
module tb_obi_cache_cmd_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, gnt, we = 1'b0, rvalid, rready = 1'b1, err;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_key;
  logic [63:0] cmd_value;
  logic        rsp_valid = 1'b0, rsp_succ = 1'b0;
  logic [63:0] rsp_value = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_cache_cmd_queue dut (
    .clk(clk), .rst_n(rst_n),
    .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr), .obi_we_i(we),
    .obi_wdata_i(wdata), .obi_rvalid_o(rvalid), .obi_rready_i(rready),
    .obi_rdata_o(rdata), .obi_err_o(err),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_op_o(cmd_op),
    .cmd_key_o(cmd_key), .cmd_value_o(cmd_value),
    .rsp_valid_i(rsp_valid), .rsp_succ_i(rsp_succ), .rsp_value_i(rsp_value)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One OBI access; returns the response sampled on the negedge after grant.
  task automatic obi(input logic w_en, input int w, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er);
    int n = 0;
    @(negedge clk);
    req = 1'b1; we = w_en; addr = 32'(w) << 2; wdata = wd;
    #1;
    while (!gnt && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $error("FAIL obi_grant_timeout observed=0 expected=1");
      req = 1'b0; we = 1'b0;
      rd = 'x; er = 1'bx;
    end else begin
      @(posedge clk);
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      chk("obi_rvalid", rvalid, 1);
      rd = rdata; er = err;
    end
  endtask

  task automatic wr(input int w, input logic [31:0] d, input string tag);
    logic [31:0] r; logic e;
    obi(1'b1, w, d, r, e);
    chk(tag, {r, 31'b0, e}, 64'h0);
  endtask

  task automatic rd(input int w, input logic [31:0] exp, input string tag);
    logic [31:0] r; logic e;
    obi(1'b0, w, 32'h0, r, e);
    chk(tag, {r, 31'b0, e}, {exp, 32'h0});
  endtask

  task automatic acc_err(input logic w_en, input int w, input string tag);
    logic [31:0] r; logic e;
    obi(w_en, w, 32'hFFFF_FFFF, r, e);
    chk(tag, {r, 31'b0, e}, 64'h1);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rvalid", rvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: stage and enqueue one command
    wr(0, 32'h3333_4444, "wr_v0");
    wr(1, 32'h1111_2222, "wr_v1");
    wr(2, 32'h0000_00A5, "wr_key");
    rd(1, 32'h1111_2222, "rd_v1");
    rd(2, 32'h0000_00A5, "rd_key");
    chk("cmd_valid_before_op", cmd_valid, 0);
    wr(3, 32'h1, "wr_op1");
    chk("cmd_valid_after_op", cmd_valid, 1);
    chk("cmd_op_1", cmd_op, 1);
    chk("cmd_key_1", cmd_key, 64'hA5);
    chk("cmd_value_1", cmd_value, 64'h1111_2222_3333_4444);

    // 2: fill the command FIFO, 5th op stalls until the controller pops
    wr(3, 32'h2, "wr_op2");
    wr(3, 32'h3, "wr_op3");
    wr(3, 32'h1, "wr_op4");
    rd(4, 32'h020, "stat_cmd_full");
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'd12; wdata = 32'h2;
    #1 chk("gnt_full_a", gnt, 0);
    @(negedge clk);
    #1 chk("gnt_full_b", gnt, 0);
    cmd_ready = 1'b1;
    #1 chk("gnt_pop_frees", gnt, 1);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0; cmd_ready = 1'b0;
    chk("op5_rvalid", rvalid, 1);
    chk("op5_err", err, 0);
    chk("head_after_pop", cmd_op, 2);
    rd(4, 32'h021, "stat_cmd4_infl1");

    // 3: one controller result, read and pop it
    @(negedge clk);
    rsp_valid = 1'b1; rsp_succ = 1'b0; rsp_value = 64'hDEAD;
    @(negedge clk) rsp_valid = 1'b0;
    rd(4, 32'h060, "stat_rsp1");
    rd(5, 32'h0000_DEAD, "rsp_val_lo");
    rd(6, 32'h0, "rsp_val_hi");
    obi(1'b0, 7, 32'h0, r, e);
    chk("pop_rdata", r, 32'h2);
    chk("pop_err", e, 0);
    rd(4, 32'h020, "stat_after_pop");

    // 4: error responses, no side effects
    acc_err(1'b0, 8, "unmapped_rd");
    acc_err(1'b0, 7, "pop_empty");
    acc_err(1'b1, 4, "wr_ro_status");
    acc_err(1'b0, 3, "rd_wo_op");
    rd(4, 32'h020, "stat_after_errs");

    // 5: response FIFO credit blocks issue
    @(negedge clk) cmd_ready = 1'b1;
    repeat (6) @(negedge clk);
    rd(4, 32'h004, "stat_infl4");
    wr(3, 32'h3, "wr_op_blocked");
    chk("cmd_valid_no_credit", cmd_valid, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      rsp_valid = 1'b1; rsp_succ = i[0]; rsp_value = 64'(i);
    end
    @(negedge clk) rsp_valid = 1'b0;
    chk("cmd_valid_rsp_full", cmd_valid, 0);
    rd(4, 32'h108, "stat_rsp_full");
    rd(5, 32'h1, "rsp_head_1");
    obi(1'b0, 7, 32'h0, r, e);
    chk("pop_full_rdata", r, 32'h3);
    chk("pop_full_err", e, 0);
    chk("cmd_valid_resumed", cmd_valid, 1);
    @(negedge clk);
    rd(4, 32'h0C1, "stat_after_resume");
    rd(5, 32'h2, "rsp_head_2");

    // 6: reset with queued commands and a pending response
    cmd_ready = 1'b0;
    wr(3, 32'h1, "wr_q1");
    wr(3, 32'h2, "wr_q2");
    rd(4, 32'h0D1, "stat_before_rst");
    @(negedge clk);
    rready = 1'b0; req = 1'b1; we = 1'b0; addr = 32'd8;
    #1 chk("gnt_key_rd", gnt, 1);
    @(posedge clk);
    @(negedge clk) req = 1'b0;
    chk("hold_rvalid_a", rvalid, 1);
    chk("hold_rdata_a", rdata, 32'hA5);
    @(negedge clk);
    chk("hold_rvalid_b", rvalid, 1);
    chk("hold_rdata_b", rdata, 32'hA5);
    rst_n = 1'b0;
    #1;
    chk("rst2_gnt", gnt, 0);
    chk("rst2_rvalid", rvalid, 0);
    chk("rst2_err", err, 0);
    chk("rst2_rdata", rdata, 0);
    chk("rst2_cmd_valid", cmd_valid, 0);
    chk("rst2_cmd_fields", {cmd_op, cmd_key}, 0);
    chk("rst2_cmd_value", cmd_value, 0);
    @(negedge clk);
    rst_n = 1'b1; rready = 1'b1;
    rd(4, 32'h0, "stat_after_rst");
    rd(2, 32'h0, "key_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
